sram_arbiter: RTL

Shares the single-port instruction/data SRAM between the IF-stage fetch port and the MEM-stage load/store port. Arbitration and fixed-latency access sequencing are done by a registered FSM. The block exports per-requester stall requests that feed the pipeline stall controller, which turns them into the global `stop` vector. Data accesses have fixed priority over fetches.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_if.sv | 50 +++++
 rtl/sram_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Shared types and constants for the instruction/data SRAM arbiter:
// FSM state encoding, owner encoding, bus widths and the latency-counter
// load helper.
package sram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // WAIT runs for LAT cycles, so the counter starts at LAT-1 and the
  // capture happens when it reaches zero.
  function automatic logic [2:0] lat_load(input int lat);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles the fetch port, the load/store port, the stall requests and the
// SRAM port of the arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives responses,
//            stall requests and the SRAM strobe/address/data)
//   master : client side (requesters, stall controller and SRAM model)
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_flush;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_valid;

  logic              data_req;
  logic [BE_W-1:0]   data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_valid;

  logic              if_stall;
  logic              mem_stall;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_flush,
    input  data_req, data_we, data_addr, data_wdata,
    input  mem_rdata,
    output inst_rdata, inst_valid, data_rdata, data_valid,
    output if_stall, mem_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr, inst_flush,
    output data_req, data_we, data_addr, data_wdata,
    output mem_rdata,
    input  inst_rdata, inst_valid, data_rdata, data_valid,
    input  if_stall, mem_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one single-port SRAM between the IF fetch port and the MEM
// load/store port. A registered IDLE/ISSUE/WAIT/RESP FSM grants one access
// at a time (data beats fetch on a tie), pulses mem_en for one cycle, waits
// LAT cycles and then presents a one-cycle valid to the owner.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : sram_arbiter_if.slave (requests, responses, stalls, SRAM port)
// Parameter:
//   LAT : SRAM read latency from the mem_en cycle, legal range 1..7
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_arbiter_if.slave      bus
);

  localparam logic [2:0] CNT_LOAD = lat_load(LAT);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              grant_data;
  logic              grant_inst;
  logic              owner;
  logic [2:0]        cnt;
  logic              drop;
  logic              drop_now;
  logic              capture;

  logic [BE_W-1:0]   mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] inst_rdata_reg;
  logic [DATA_W-1:0] data_rdata_reg;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and grant decode
  always_comb begin
    state_nxt  = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (bus.data_req) begin
          grant_data = 1'b1;
          state_nxt  = ARB_ISSUE;
        end else if (bus.inst_req) begin
          grant_inst = 1'b1;
          state_nxt  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (cnt == 3'd0) state_nxt = ARB_RESP;
      // The requester still holds the finished request here, so RESP
      // never re-arbitrates.
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // A flush in the capture cycle itself must already block the inst_rdata
  // update, so the registered drop flag is combined with the live flush.
  assign drop_now = bus.inst_flush && (owner == OWN_INST) && (state != ARB_IDLE);
  assign capture  = (state == ARB_WAIT) && (cnt == 3'd0);

  // Access bookkeeping, SRAM request registers and response data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner          <= OWN_INST;
      cnt            <= 3'd0;
      drop           <= 1'b0;
      mem_we_reg     <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      if (grant_data || grant_inst) begin
        owner         <= grant_data ? OWN_DATA : OWN_INST;
        mem_addr_reg  <= grant_data ? bus.data_addr : bus.inst_addr;
        mem_we_reg    <= grant_data ? bus.data_we : '0;
        mem_wdata_reg <= bus.data_wdata;
      end

      if (state == ARB_ISSUE)                   cnt <= CNT_LOAD;
      else if (state == ARB_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;

      // RESP always leads to IDLE, so clearing here clears on IDLE entry.
      if (state == ARB_RESP) drop <= 1'b0;
      else if (drop_now)     drop <= 1'b1;

      if (capture) begin
        if (owner == OWN_DATA) begin
          if (mem_we_reg == '0) data_rdata_reg <= bus.mem_rdata;
        end else if (!(drop || drop_now)) begin
          inst_rdata_reg <= bus.mem_rdata;
        end
      end
    end
  end

  // Strobes and valids decode from state so an async reset kills them at once
  assign bus.mem_en     = (state == ARB_ISSUE);
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;

  assign bus.inst_valid = (state == ARB_RESP) && (owner == OWN_INST) && !drop;
  assign bus.data_valid = (state == ARB_RESP) && (owner == OWN_DATA);
  assign bus.inst_rdata = inst_rdata_reg;
  assign bus.data_rdata = data_rdata_reg;

  assign bus.if_stall   = bus.inst_req && !bus.inst_valid;
  assign bus.mem_stall  = bus.data_req && !bus.data_valid;

endmodule
